// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit rotation, dead time between
// digits, BCD decode with leading-zero blanking, all outputs registered.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    slot_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [31:0]           DEAD_U    = DEAD_CYCLES;
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;

    logic [NUM_DIGITS-1:0]   blank;
    logic                    upper_zero;
    logic [3:0]              nibble;
    logic [6:0]              pat;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    in_dead;

    // Active-low pattern, seg[6]=a .. seg[0]=g; non-BCD nibbles show nothing.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Digit i blanks when it and every more significant nibble are zero.
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_q[4*i +: 4] == 4'd0);
            blank[i]   = LZ_BLANK && (i != 0) && upper_zero;
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        disp_d  = disp_q;
        tick_d  = 1'b0;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        if (load) begin
            disp_d = digits_in;
        end

        nibble  = disp_q[4*int'(idx_q) +: 4];
        pat     = blank[idx_q] ? 7'b1111111 : decode(nibble);
        onehot  = NUM_DIGITS'(1) << idx_q;
        in_dead = {{(32-PW){1'b0}}, presc_q} < DEAD_U;

        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (!in_dead) begin
            seg_d = SEG_ACTIVE_LOW ? pat : ~pat;
            an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign slot_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (default and inverted polarity)
// share stimulus; a cycle model pushes expected outputs that each test pops.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        tick_a, tick_b;

    typedef struct packed {
        logic [6:0] seg_a;
        logic [3:0] an_a;
        logic [6:0] seg_b;
        logic [3:0] an_b;
        logic       tick;
    } exp_t;

    exp_t        sb_q[$];
    int          vecs = 0;
    int          errs = 0;
    int          m_presc = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = 16'h0000;

    // Expected segment pattern per digit for each table load, index = digit number.
    logic [15:0] val_tab [4] = '{16'h0050, 16'h0000, 16'hF0A9, 16'h0008};
    logic [6:0]  pat_tab [4][4] = '{
        '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111},
        '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111},
        '{7'b0000100, 7'b1111111, 7'b0000001, 7'b1111111},
        '{7'b0000000, 7'b1111111, 7'b1111111, 7'b1111111}
    };

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
        .seg(seg_a), .an(an_a), .slot_tick(tick_a)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
        .seg(seg_b), .an(an_b), .slot_tick(tick_b)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_pat(input logic [3:0] n);
        case (n)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        exp_t       e;
        logic       dead;
        logic [6:0] p;
        if (rst) begin
            m_presc = 0;
            m_idx   = 0;
            m_disp  = 16'h0000;
            sb_q.delete();
        end else begin
            dead = (m_presc < 1);
            if (m_idx > 0 && (m_disp >> (4 * m_idx)) == 16'h0000)
                p = 7'b1111111;
            else
                p = ref_pat(m_disp[4*m_idx +: 4]);
            e.seg_a = dead ? 7'b1111111 : p;
            e.an_a  = dead ? 4'b1111 : ~(4'b0001 << m_idx);
            e.seg_b = ~e.seg_a;
            e.an_b  = ~e.an_a;
            e.tick  = (m_presc == 3);
            sb_q.push_back(e);
            if (m_presc == 3) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % 4;
            end else begin
                m_presc = m_presc + 1;
            end
            if (load) m_disp = digits_in;
        end
    end

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; load = 1'b1; digits_in = 16'h9999;
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if ({seg_a, an_a, tick_a, seg_b, an_b, tick_b} !== {7'h7F, 4'hF, 1'b0, 7'h00, 4'h0, 1'b0}) begin
                errs++;
                $display("FAIL reset_hold got %b_%b_%b %b_%b_%b required 1111111_1111_0 0000000_0000_0",
                         seg_a, an_a, tick_a, seg_b, an_b, tick_b);
            end
        end
        rst = 1'b0; load = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vecs++;
            if (sb_q.size() == 0) begin
                errs++; $display("FAIL reset_sb empty scoreboard at cycle %0d", c);
            end else begin
                e = sb_q.pop_front();
                if ({seg_a, an_a, seg_b, an_b, tick_a, tick_b} !== {e, e.tick}) begin
                    errs++;
                    $display("FAIL reset_scan got %b required %b", {seg_a, an_a, seg_b, an_b, tick_a, tick_b}, {e, e.tick});
                end
            end
            if (c == 0) begin
                vecs++;
                if (an_a !== 4'b1111) begin errs++; $display("FAIL reset_dead an got %b required 1111", an_a); end
            end
            if (c == 1) begin
                vecs++;
                if ({an_a, seg_a} !== {4'b1110, 7'b0000001}) begin
                    errs++; $display("FAIL reset_first_digit got %b %b required 1110 0000001", an_a, seg_a);
                end
            end
        end
    endtask

    task automatic test_scan_1234();
        exp_t e;
        int   ticks = 0;
        int   last  = -1;
        load = 1'b1; digits_in = 16'h1234;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) load = 1'b0;
            vecs++;
            if (sb_q.size() == 0) begin
                errs++; $display("FAIL scan_sb empty scoreboard at cycle %0d", c);
            end else begin
                e = sb_q.pop_front();
                if ({seg_a, an_a, seg_b, an_b, tick_a, tick_b} !== {e, e.tick}) begin
                    errs++;
                    $display("FAIL scan_1234 got %b required %b", {seg_a, an_a, seg_b, an_b, tick_a, tick_b}, {e, e.tick});
                end
            end
            if (c >= 1) begin
                vecs++;
                if ((an_a == 4'b1110 && seg_a !== 7'b1001100) || (an_a == 4'b1101 && seg_a !== 7'b0000110) ||
                    (an_a == 4'b1011 && seg_a !== 7'b0010010) || (an_a == 4'b0111 && seg_a !== 7'b1001111) ||
                    (an_a == 4'b1111 && seg_a !== 7'b1111111)) begin
                    errs++; $display("FAIL scan_digit an %b seg got %b", an_a, seg_a);
                end
            end
            if (tick_a) begin
                ticks++;
                if (last >= 0) begin
                    vecs++;
                    if (c - last != 4) begin errs++; $display("FAIL tick_spacing got %0d required 4", c - last); end
                end
                last = c;
            end
        end
        vecs++;
        if (ticks != 4) begin errs++; $display("FAIL tick_count got %0d required 4", ticks); end
    endtask

    task automatic test_digit_patterns();
        exp_t       e;
        logic [3:0] oh;
        logic       hit;
        for (int v = 0; v < 4; v++) begin
            load = 1'b1; digits_in = val_tab[v];
            for (int c = 0; c < 17; c++) begin
                @(negedge clk);
                if (c == 0) load = 1'b0;
                vecs++;
                if (sb_q.size() == 0) begin
                    errs++; $display("FAIL pat_sb empty scoreboard v%0d c%0d", v, c);
                end else begin
                    e = sb_q.pop_front();
                    if ({seg_a, an_a, seg_b, an_b, tick_a, tick_b} !== {e, e.tick}) begin
                        errs++;
                        $display("FAIL pat_model v%0d got %b required %b", v,
                                 {seg_a, an_a, seg_b, an_b, tick_a, tick_b}, {e, e.tick});
                    end
                end
                if (c >= 1) begin
                    hit = 1'b0;
                    vecs++;
                    if (an_a == 4'b1111) begin
                        hit = 1'b1;
                        if ({seg_a, an_b, seg_b} !== {7'h7F, 4'h0, 7'h00}) begin
                            errs++; $display("FAIL pat_dead v%0d got %b %b %b", v, seg_a, an_b, seg_b);
                        end
                    end
                    for (int d = 0; d < 4; d++) begin
                        oh = 4'b0001 << d;
                        if (an_a == ~oh) begin
                            hit = 1'b1;
                            if ({seg_a, an_b, seg_b} !== {pat_tab[v][d], oh, ~pat_tab[v][d]}) begin
                                errs++;
                                $display("FAIL pat_digit v%0d d%0d got %b %b %b required %b %b %b", v, d,
                                         seg_a, an_b, seg_b, pat_tab[v][d], oh, ~pat_tab[v][d]);
                            end
                        end
                    end
                    if (!hit) begin errs++; $display("FAIL pat_anode v%0d illegal an %b", v, an_a); end
                end
            end
        end
    endtask

    task automatic test_load_mid_slot();
        exp_t e;
        int   ld_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vecs++;
            if (sb_q.size() == 0) begin
                errs++; $display("FAIL mid_sb empty scoreboard at cycle %0d", c);
            end else begin
                e = sb_q.pop_front();
                if ({seg_a, an_a, seg_b, an_b, tick_a, tick_b} !== {e, e.tick}) begin
                    errs++;
                    $display("FAIL mid_model got %b required %b", {seg_a, an_a, seg_b, an_b, tick_a, tick_b}, {e, e.tick});
                end
            end
            load = 1'b0;
            if (ld_cyc < 0 && an_a == 4'b1101) begin
                load = 1'b1; digits_in = 16'h0070; ld_cyc = c;
            end
            if (ld_cyc >= 0 && c == ld_cyc + 2) begin
                vecs++;
                if ({an_a, seg_a, tick_a} !== {4'b1101, 7'b0001111, 1'b1}) begin
                    errs++; $display("FAIL mid_load got %b %b %b required 1101 0001111 1", an_a, seg_a, tick_a);
                end
            end
        end
        vecs++;
        if (ld_cyc < 0) begin errs++; $display("FAIL mid_wait digit1 slot never seen"); end
    endtask

    task automatic test_reset_mid_slot();
        exp_t e;
        bit   found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            vecs++;
            if (sb_q.size() == 0) begin
                errs++; $display("FAIL rmid_sb empty scoreboard at cycle %0d", c);
            end else begin
                e = sb_q.pop_front();
                if ({seg_a, an_a, seg_b, an_b, tick_a, tick_b} !== {e, e.tick}) begin
                    errs++;
                    $display("FAIL rmid_model got %b required %b", {seg_a, an_a, seg_b, an_b, tick_a, tick_b}, {e, e.tick});
                end
            end
            if (an_a == 4'b1011) found = 1'b1;
        end
        vecs++;
        if (!found) begin errs++; $display("FAIL rmid_wait digit2 slot never seen"); end
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({seg_a, an_a, tick_a, seg_b, an_b, tick_b} !== {7'h7F, 4'hF, 1'b0, 7'h00, 4'h0, 1'b0}) begin
            errs++;
            $display("FAIL rmid_async got %b_%b_%b %b_%b_%b required 1111111_1111_0 0000000_0000_0",
                     seg_a, an_a, tick_a, seg_b, an_b, tick_b);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vecs++;
            if (sb_q.size() == 0) begin
                errs++; $display("FAIL rmid_sb2 empty scoreboard at cycle %0d", c);
            end else begin
                e = sb_q.pop_front();
                if ({seg_a, an_a, seg_b, an_b, tick_a, tick_b} !== {e, e.tick}) begin
                    errs++;
                    $display("FAIL rmid_after got %b required %b", {seg_a, an_a, seg_b, an_b, tick_a, tick_b}, {e, e.tick});
                end
            end
            if (c < 2) begin
                vecs++;
                if (an_a !== ((c == 0) ? 4'b1111 : 4'b1110)) begin
                    errs++; $display("FAIL rmid_restart c%0d an got %b", c, an_a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_digit_patterns();
        test_load_mid_slot();
        test_reset_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal 1..8.
REQ-002 The module SHALL have parameter REFRESH_DIV, default 50000: clocks per digit slot, legal 2..2^20.
REQ-003 The module SHALL have parameter DEAD_CYCLES, default 2: clocks at the start of each slot with all anodes off, legal 0..REFRESH_DIV-1.
REQ-004 The module SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = segment lit when its bit is 0.
REQ-005 The module SHALL have parameter AN_ACTIVE_LOW, default 1: 1 = digit enabled when its anode bit is 0.
REQ-006 The module SHALL have parameter LZ_BLANK, default 1: 1 = leading-zero blanking enabled.
REQ-007 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port digits_in, input, 4*NUM_DIGITS bits: BCD digits; nibble i is digit i, digit 0 least significant.
REQ-010 Port load, input, 1 bit: when high, digits_in is captured at the clock edge.
REQ-011 Port seg, output, 7 bits: segment drive, registered; seg[6]=a through seg[0]=g.
REQ-012 Port an, output, NUM_DIGITS bits: one-hot digit enable, registered.
REQ-013 Port slot_tick, output, 1 bit: registered one-cycle pulse at each digit-slot change.

Function
REQ-014 The block SHALL hold a display register, updated from digits_in only on clock edges where load=1; displayed data SHALL change only via this register.
REQ-015 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 to 0.
REQ-016 slot_tick SHALL be 1 in exactly the cycle after each prescaler wrap, else 0.
REQ-017 The decode SHALL be active-low, 0..9 = 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100; nibbles 10..15 SHALL decode to all-off (1111111).
REQ-018 When SEG_ACTIVE_LOW=0, seg SHALL be the bitwise inverse of the REQ-017 pattern, including all-off.
REQ-019 With LZ_BLANK=1, digit i (i>0) SHALL show all-off when nibble i and every higher nibble are 0; digit 0 SHALL never be zero-blanked.
REQ-020 While the prescaler is below DEAD_CYCLES, an SHALL be all-inactive and seg SHALL be all-off; otherwise only the bit of the current index SHALL be active.
REQ-021 seg/an SHALL lag the prescaler/index/display-register state by exactly one clock.
REQ-022 If load occurs mid-slot, the new value SHALL appear on seg on the cycle after capture, without disturbing the prescaler or index.
REQ-023 Exactly zero or one an bit SHALL be active in any cycle.

Reset
REQ-024 While rst=1: prescaler=0, index=0, display register=0, slot_tick=0, an all-inactive, seg all-off, regardless of clk.
REQ-025 After rst deasserts, the first slot SHALL begin at index 0 with a full dead time; a load asserted during reset SHALL be ignored.

Verification
REQ-026 Defaults except REFRESH_DIV=4, DEAD_CYCLES=1: load 16'h1234 -> per 4-clock slot: 1 clock an=1111, then 3 clocks an=1110, seg=1001100 (4); next slot an=1101, seg=0000110 (3); slot_tick pulses every 4 clocks.
REQ-027 LZ_BLANK=1, load 16'h0050 -> digit3 and digit2 seg=1111111 with anode active; digit1=0100100 (5); digit0=0000001 (0); load 16'h0000 -> only digit0 shows 0000001.
REQ-028 Load 16'hF0A9 -> digits 3 and 1 (nibbles F, A) all-off; digit0=0000100 (9); digit2 zero-blanked only if LZ_BLANK=1 and the higher digit were 0; here F is nonzero, so digit2=0000001.
REQ-029 Assert rst mid-slot at index 2 -> an=1111, seg=1111111, slot_tick=0 in the same cycle, asynchronously; after release, index 0 slot begins with dead time.
REQ-030 SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, load 16'h0008 -> digit0 active: an=0001, seg=1111111; blanked slots: seg=0000000; dead time: an=0000.
